// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with per-entry saturating direction
// counters, same-cycle mispredict redirect and resolved-branch statistics.
module branch_predictor #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned ENTRIES = 64,
    parameter int unsigned TAG_W   = 8,
    parameter int unsigned CNT_W   = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            bp_clear,
    input  logic [XLEN-1:0] if_pc,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    output logic            pred_hit,
    input  logic            upd_valid,
    input  logic [XLEN-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic [XLEN-1:0] upd_target,
    input  logic            upd_pred_taken,
    input  logic [XLEN-1:0] upd_pred_target,
    output logic            redirect,
    output logic [XLEN-1:0] redirect_pc,
    output logic [31:0]     stat_branches,
    output logic [31:0]     stat_mispred
);

    localparam int unsigned IDX_W  = $clog2(ENTRIES);
    localparam int unsigned TAG_LO = IDX_W + 2;
    localparam int unsigned TAG_HI = TAG_LO + TAG_W - 1;
    localparam int unsigned STAT_W = 32;

    // Counter encodings: saturation ceiling, weakly taken, weakly not-taken.
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_WT  = CNT_W'(1 << (CNT_W - 1));
    localparam logic [CNT_W-1:0] CNT_WNT = CNT_W'((1 << (CNT_W - 1)) - 1);

    // Table storage.
    logic              valid_q  [ENTRIES];
    logic              valid_d  [ENTRIES];
    logic [TAG_W-1:0]  tag_q    [ENTRIES];
    logic [TAG_W-1:0]  tag_d    [ENTRIES];
    logic [XLEN-1:0]   target_q [ENTRIES];
    logic [XLEN-1:0]   target_d [ENTRIES];
    logic [CNT_W-1:0]  cnt_q    [ENTRIES];
    logic [CNT_W-1:0]  cnt_d    [ENTRIES];

    // Statistics.
    logic [STAT_W-1:0] stat_branches_q;
    logic [STAT_W-1:0] stat_branches_d;
    logic [STAT_W-1:0] stat_mispred_q;
    logic [STAT_W-1:0] stat_mispred_d;

    // Address decode for both ports.
    logic [IDX_W-1:0]  if_idx;
    logic [TAG_W-1:0]  if_tag;
    logic [XLEN-1:0]   if_pc_inc;
    logic [IDX_W-1:0]  upd_idx;
    logic [TAG_W-1:0]  upd_tag;
    logic [XLEN-1:0]   upd_pc_inc;
    logic              upd_hit;
    logic              mispredict;

    assign if_idx     = if_pc[IDX_W+1:2];
    assign if_tag     = if_pc[TAG_HI:TAG_LO];
    assign if_pc_inc  = if_pc + XLEN'(4);
    assign upd_idx    = upd_pc[IDX_W+1:2];
    assign upd_tag    = upd_pc[TAG_HI:TAG_LO];
    assign upd_pc_inc = upd_pc + XLEN'(4);

    // Fetch-side lookup reads only registered table state.
    always_comb begin
        pred_hit    = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
        pred_taken  = pred_hit && cnt_q[if_idx][CNT_W-1];
        pred_target = pred_taken ? target_q[if_idx] : if_pc_inc;
    end

    // Resolve-side mispredict detection and correct next PC.
    always_comb begin
        mispredict  = upd_valid &&
                      ((upd_pred_taken != upd_taken) ||
                       (upd_taken && (upd_pred_target != upd_target)));
        redirect    = mispredict;
        redirect_pc = upd_taken ? upd_target : upd_pc_inc;
    end

    // Table next state: clear dominates; otherwise train on hit or allocate on taken miss.
    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        cnt_d    = cnt_q;
        upd_hit  = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

        if (bp_clear) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                valid_d[i] = 1'b0;
            end
        end else if (upd_valid) begin
            if (upd_hit) begin
                if (upd_taken) begin
                    if (cnt_q[upd_idx] != CNT_MAX) begin
                        cnt_d[upd_idx] = cnt_q[upd_idx] + CNT_W'(1);
                    end
                    target_d[upd_idx] = upd_target;
                end else if (cnt_q[upd_idx] != '0) begin
                    cnt_d[upd_idx] = cnt_q[upd_idx] - CNT_W'(1);
                end
            end else if (upd_taken) begin
                valid_d[upd_idx]  = 1'b1;
                tag_d[upd_idx]    = upd_tag;
                target_d[upd_idx] = upd_target;
                cnt_d[upd_idx]    = CNT_WT;
            end
        end
    end

    // Statistics next state; both wrap naturally at 2^32.
    always_comb begin
        stat_branches_d = stat_branches_q + STAT_W'(upd_valid);
        stat_mispred_d  = stat_mispred_q + STAT_W'(mispredict);
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                cnt_q[i]    <= CNT_WNT;
            end
            stat_branches_q <= '0;
            stat_mispred_q  <= '0;
        end else begin
            valid_q         <= valid_d;
            tag_q           <= tag_d;
            target_q        <= target_d;
            cnt_q           <= cnt_d;
            stat_branches_q <= stat_branches_d;
            stat_mispred_q  <= stat_mispred_d;
        end
    end

    assign stat_branches = stat_branches_q;
    assign stat_mispred  = stat_mispred_q;

endmodule
